hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard detector for the 5-stage MIPS core, sitting beside the ID stage.
- Produces the `bubble` input of the control decoder, plus PC and IF/ID register enables and the IF/ID flush.
- Tracks in-flight loads internally with a shadow register, detects load-use hazards, and sequences multi-cycle load stalls.
- Flushes on a jump resolved in ID and on a taken branch resolved in EX.

Parameters:
- LOAD_STALL_CYCLES, 1, bubble cycles per load-use hazard (1 = MEM->EX forwarding present, 2 = no forwarding); legal range 1..3.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs  input  REG_ADDR_W  ID source register rs
- id_rt  input  REG_ADDR_W  ID source register rt
- id_uses_rt  input  1  ID instruction reads rt (R-type, BEQ, SW)
- id_mem_read  input  1  ID instruction is a load (decoder mem_read)
- id_dest  input  REG_ADDR_W  ID destination register after reg_dst mux
- id_jump  input  1  ID instruction is J/JAL (decoder jump)
- ex_branch_taken  input  1  branch in EX resolved taken this cycle
- bubble  output  1  to decoder; zeroes ID/EX control
- pc_write  output  1  PC register enable
- ifid_write  output  1  IF/ID register enable
- ifid_flush  output  1  clear IF/ID to NOP on the next edge

Behaviour:
- **Reset (async):** state=RUN, cnt=0, ld_valid=0, ld_dst=0.
  - While reset=1, outputs are forced: bubble=1, pc_write=0, ifid_write=0, ifid_flush=0.
- **Clocking and output timing:**
  - Outputs are combinational from the current state and current inputs.
  - All internal registers update on the rising clk edge.
- **Shadow register:** each edge, ld_valid <= id_valid & id_mem_read & ~bubble & ~ex_branch_taken, and ld_dst <= id_dest.
- **Hazard term:** hit = id_valid & ld_valid & (ld_dst != 0) & ((id_rs == ld_dst) | (id_uses_rt & (id_rt == ld_dst))).
- **States:** RUN and LOAD_STALL.
- **Priority:** ex_branch_taken > load stall > id_jump.
- **ex_branch_taken=1 (any state):**
  - Outputs: bubble=1, ifid_flush=1, pc_write=1, ifid_write=1.
  - Next: state=RUN, cnt=0, ld_valid=0.
  - A load stall in progress is aborted.
- **RUN with hit=1:**
  - Outputs: bubble=1, pc_write=0, ifid_write=0, ifid_flush=0.
  - If LOAD_STALL_CYCLES>1: next state=LOAD_STALL, cnt=LOAD_STALL_CYCLES-1.
  - Otherwise stay in RUN.
- **LOAD_STALL:**
  - Outputs: bubble=1, pc_write=0, ifid_write=0; id_jump is ignored.
  - cnt decrements each cycle; at cnt==1, next state=RUN and cnt=0.
  - The hit term is not re-evaluated while in LOAD_STALL.
- **RUN, no hit, id_jump & id_valid:**
  - Outputs: bubble=0 (JAL still writes $31), pc_write=1, ifid_write=1, ifid_flush=1.
- **RUN otherwise:** bubble=0, pc_write=1, ifid_write=1, ifid_flush=0.
- **Register $0:** id_dest=0 loads never cause a stall.
- **Back-to-back loads:**
  - A dependent load following a load stalls normally.
  - After the stall, the shadow holds the bubble (invalid), so there is no double count.
- **Reset mid-stall:** returns immediately to the reset values; no residual stall after reset is released.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, two extra outputs are added:
  - stall_count[15:0]: increments every cycle with bubble=1 and ex_branch_taken=0.
  - flush_count[15:0]: increments every cycle with ifid_flush=1.
- Both counters saturate at 16'hFFFF and are cleared by reset.
- When not defined: no extra ports, no counter logic; all other behaviour identical.

Test Plan:
- **Reset:** reset=1 for 3 cycles, release -> bubble=1, pc_write=0, ifid_write=0 during reset; bubble=0, pc_write=1 in the first cycle after release.
- **Load-use, 1-cycle stall:** LOAD_STALL_CYCLES=1; lw with id_dest=8, next ID id_rs=8 -> exactly 1 cycle of bubble=1, pc_write=0, ifid_write=0, then normal flow.
- **Load-use, 2-cycle stall with rt dependency:** LOAD_STALL_CYCLES=2; lw dest=9, next id_rt=9, id_uses_rt=1 -> 2 bubble cycles. Repeat with id_uses_rt=0 -> 0 stall cycles.
- **Load to $0:** lw dest=0, next id_rs=0 -> no stall.
- **Branch during stall:** ex_branch_taken=1 during the first cycle of a 2-cycle stall -> ifid_flush=1, bubble=1, pc_write=1 that cycle; the next cycle is in RUN with bubble=0.
- **Jump and stats:** JAL in ID with no hazard -> ifid_flush=1, bubble=0 for 1 cycle.
  - With HAZARD_STATS_EN defined: flush_count=1 after the jump, and stall_count=3 after the 1-cycle and 2-cycle stall scenarios.

Source files
------------

// File: rtl/hazard_unit.sv
// Load-use / control-flow hazard detector beside the ID stage of the 5-stage MIPS core.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module hazard_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_jump,
  input  logic                  ex_branch_taken,
  output logic                  bubble,
  output logic                  pc_write,
  output logic                  ifid_write,
`ifdef HAZARD_STATS_EN
  output logic                  ifid_flush,
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count
`else
  output logic                  ifid_flush
`endif
);

  typedef enum logic {RUN, LOAD_STALL} state_t;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [1:0]              cnt, cnt_nxt;
  logic                    ld_valid, ld_valid_nxt;
  logic [REG_ADDR_W-1:0]   ld_dst;
  logic                    hit;

  // Writes to $0 are discarded, so a load targeting it can never feed a consumer.
  assign hit = id_valid & ld_valid & (ld_dst != '0) &
               ((id_rs == ld_dst) | (id_uses_rt & (id_rt == ld_dst)));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bubble     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;

    if (ex_branch_taken) begin
      bubble     = 1'b1;
      ifid_flush = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = 2'd0;
    end else if (state == LOAD_STALL) begin
      bubble     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if (cnt <= 2'd1) begin
        state_nxt = RUN;
        cnt_nxt   = 2'd0;
      end else begin
        cnt_nxt = cnt - 2'd1;
      end
    end else if (hit) begin
      bubble     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = LOAD_STALL;
        cnt_nxt   = STALL_INIT;
      end
    end else if (id_jump & id_valid) begin
      ifid_flush = 1'b1;
    end

    if (reset) begin
      bubble     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
    end

    // A load squashed by a bubble or a branch never reaches EX, so it is not tracked.
    ld_valid_nxt = id_valid & id_mem_read & ~bubble & ~ex_branch_taken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= 2'd0;
      ld_valid <= 1'b0;
      ld_dst   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ld_valid <= ld_valid_nxt;
      ld_dst   <= id_dest;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (bubble & ~ex_branch_taken) stall_count <= sat_inc(stall_count);
      if (ifid_flush)                flush_count <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector scoreboard bench for hazard_unit; drives 1-cycle and 2-cycle stall
// instances from a shared stimulus stream and checks each against hand-computed outputs.
module tb_hazard_unit;

  typedef struct {
    int         idx;
    logic       rst;
    logic       br;
    logic [3:0] e1;
    logic [3:0] e2;
  } exp_t;

  // Output code order: {bubble, pc_write, ifid_write, ifid_flush}
  localparam logic [3:0] NRM = 4'b0110;
  localparam logic [3:0] STL = 4'b1000;
  localparam logic [3:0] RST = 4'b1000;
  localparam logic [3:0] BRF = 4'b1111;
  localparam logic [3:0] JMP = 4'b0111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_uses_rt = 1'b0, id_mem_read = 1'b0, id_jump = 1'b0, ex_branch_taken = 1'b0;

  logic b1, pw1, iw1, fl1;
  logic b2, pw2, iw2, fl2;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fc1, sc2, fc2;
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   vid   = 0;
  int   m_s1 = 0, m_f1 = 0, m_s2 = 0, m_f2 = 0;

  always #5 clk = ~clk;

  hazard_unit #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .bubble(b1), .pc_write(pw1), .ifid_write(iw1),
`ifdef HAZARD_STATS_EN
    .ifid_flush(fl1), .stall_count(sc1), .flush_count(fc1)
`else
    .ifid_flush(fl1)
`endif
  );

  hazard_unit #(.LOAD_STALL_CYCLES(2), .REG_ADDR_W(5)) u2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read), .id_dest(id_dest),
    .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
    .bubble(b2), .pc_write(pw2), .ifid_write(iw2),
`ifdef HAZARD_STATS_EN
    .ifid_flush(fl2), .stall_count(sc2), .flush_count(fc2)
`else
    .ifid_flush(fl2)
`endif
  );

  task automatic step(input logic rst, input logic vld, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mr,
                      input logic [4:0] dst, input logic jmp, input logic br,
                      input logic [3:0] e1, input logic [3:0] e2);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = vld; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_mem_read = mr; id_dest = dst; id_jump = jmp; ex_branch_taken = br;
    e.idx = vid; e.rst = rst; e.br = br; e.e1 = e1; e.e2 = e2;
    sb.push_back(e);
    vid++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] g1, g2;
      e  = sb.pop_front();
      g1 = {b1, pw1, iw1, fl1};
      g2 = {b2, pw2, iw2, fl2};
      n_vec++;
      if (g1 !== e.e1) begin
        n_bad++;
        $display("FAIL v%0d lsc1 outputs: got %b want %b", e.idx, g1, e.e1);
      end
      n_vec++;
      if (g2 !== e.e2) begin
        n_bad++;
        $display("FAIL v%0d lsc2 outputs: got %b want %b", e.idx, g2, e.e2);
      end
      if (e.rst) begin
        m_s1 = 0; m_f1 = 0; m_s2 = 0; m_f2 = 0;
      end else begin
        if (e.e1[3] && !e.br) m_s1++;
        if (e.e1[0])          m_f1++;
        if (e.e2[3] && !e.br) m_s2++;
        if (e.e2[0])          m_f2++;
      end
    end
  end

  initial begin
    int guard;
    // reset held three cycles, then normal flow
    step(1,0,0,0,0,0,0,0,0,RST,RST);
    step(1,0,0,0,0,0,0,0,0,RST,RST);
    step(1,0,0,0,0,0,0,0,0,RST,RST);
    step(0,1,1,2,1,0,3,0,0,NRM,NRM);
    // reset asserted mid-stall leaves no residual stall
    step(0,1,1,0,0,1,8,0,0,NRM,NRM);
    step(0,1,8,0,0,0,10,0,0,STL,STL);
    step(1,1,8,0,0,0,10,0,0,RST,RST);
    step(0,1,8,0,0,0,10,0,0,NRM,NRM);
    // load-use on rs
    step(0,1,1,2,0,1,8,0,0,NRM,NRM);
    step(0,1,8,2,1,0,10,0,0,STL,STL);
    step(0,1,8,2,1,0,10,0,0,NRM,STL);
    step(0,1,4,5,1,0,6,0,0,NRM,NRM);
    // load-use on rt, then rt not read
    step(0,1,1,0,0,1,9,0,0,NRM,NRM);
    step(0,1,2,9,1,0,11,0,0,STL,STL);
    step(0,1,2,9,1,0,11,0,0,NRM,STL);
    step(0,1,4,5,1,0,6,0,0,NRM,NRM);
    step(0,1,1,0,0,1,9,0,0,NRM,NRM);
    step(0,1,2,9,0,0,11,0,0,NRM,NRM);
    // load to $0
    step(0,1,1,0,0,1,0,0,0,NRM,NRM);
    step(0,1,0,0,1,0,3,0,0,NRM,NRM);
    // back-to-back dependent loads
    step(0,1,1,0,0,1,8,0,0,NRM,NRM);
    step(0,1,8,0,0,1,12,0,0,STL,STL);
    step(0,1,8,0,0,1,12,0,0,NRM,STL);
    step(0,1,8,0,0,1,12,0,0,NRM,NRM);
    step(0,1,12,0,0,0,13,0,0,STL,STL);
    step(0,1,12,0,0,0,13,0,0,NRM,STL);
    step(0,1,4,5,1,0,6,0,0,NRM,NRM);
    // taken branch aborts stall in progress / beats a fresh hit / kills a load in ID
    step(0,1,1,0,0,1,9,0,0,NRM,NRM);
    step(0,1,9,0,0,0,14,0,0,STL,STL);
    step(0,1,9,0,0,0,14,0,1,BRF,BRF);
    step(0,1,9,0,0,0,14,0,0,NRM,NRM);
    step(0,1,1,0,0,1,9,0,0,NRM,NRM);
    step(0,1,9,0,0,0,14,0,1,BRF,BRF);
    step(0,1,9,0,0,0,14,0,0,NRM,NRM);
    step(0,1,1,0,0,1,9,0,1,BRF,BRF);
    step(0,1,9,0,0,0,14,0,0,NRM,NRM);
    // jump, invalid jump, and stall priority over jump
    step(0,1,1,0,0,0,31,1,0,JMP,JMP);
    step(0,0,1,0,0,0,31,1,0,NRM,NRM);
    step(0,1,1,0,0,1,8,0,0,NRM,NRM);
    step(0,1,8,0,0,0,31,1,0,STL,STL);
    step(0,1,8,0,0,0,31,1,0,JMP,STL);
    step(0,0,0,0,0,0,0,0,0,NRM,NRM);
    // id_valid=0 neither consumes nor produces a tracked load
    step(0,1,1,0,0,1,8,0,0,NRM,NRM);
    step(0,0,8,0,0,0,10,0,0,NRM,NRM);
    step(0,0,1,0,0,1,8,0,0,NRM,NRM);
    step(0,1,8,0,0,0,10,0,0,NRM,NRM);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: %0d left, want 0", sb.size());
    end
    @(posedge clk);
    #1;
`ifdef HAZARD_STATS_EN
    n_vec++;
    if (sc1 !== 16'(m_s1)) begin n_bad++; $display("FAIL lsc1 stall_count: got %0d want %0d", sc1, m_s1); end
    n_vec++;
    if (fc1 !== 16'(m_f1)) begin n_bad++; $display("FAIL lsc1 flush_count: got %0d want %0d", fc1, m_f1); end
    n_vec++;
    if (sc2 !== 16'(m_s2)) begin n_bad++; $display("FAIL lsc2 stall_count: got %0d want %0d", sc2, m_s2); end
    n_vec++;
    if (fc2 !== 16'(m_f2)) begin n_bad++; $display("FAIL lsc2 flush_count: got %0d want %0d", fc2, m_f2); end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
